// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - phase encodings and config helpers for the washing-machine sequencer
package wm_pkg;

    typedef logic [2:0] phase_t;

    localparam phase_t PH_IDLE   = 3'd0;
    localparam phase_t PH_FILL   = 3'd1;
    localparam phase_t PH_WASH   = 3'd2;
    localparam phase_t PH_RINSE  = 3'd3;
    localparam phase_t PH_SPIN   = 3'd4;
    localparam phase_t PH_PAUSED = 3'd5;

    // Wash count of 0 means a single cycle; anything above max saturates.
    function automatic int unsigned clamp_count(input int unsigned value, input int unsigned max);
        if (value == 0) begin
            return 1;
        end else if (value > max) begin
            return max;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/wm_program_controller_if.sv
// rtl/wm_program_controller_if.sv - user-input and driver-facing signals of the sequencer
interface wm_program_controller_if #(
    parameter int DUR_W  = 16,
    parameter int WCNT_W = 3
);
    logic              coin_in;
    logic              abort;
    logic              timer_pause;
    logic [WCNT_W-1:0] wash_count;
    logic [DUR_W-1:0]  fill_dur;
    logic [DUR_W-1:0]  wash_dur;
    logic [DUR_W-1:0]  rinse_dur;
    logic [DUR_W-1:0]  spin_dur;
    logic [2:0]        phase;
    logic              busy;
    logic [WCNT_W-1:0] wash_idx;
    logic              wash_done;

    modport master (
        output coin_in, abort, timer_pause, wash_count,
        output fill_dur, wash_dur, rinse_dur, spin_dur,
        input  phase, busy, wash_idx, wash_done
    );

    modport slave (
        input  coin_in, abort, timer_pause, wash_count,
        input  fill_dur, wash_dur, rinse_dur, spin_dur,
        output phase, busy, wash_idx, wash_done
    );
endinterface

// File: rtl/wm_tick_prescaler.sv
// rtl/wm_tick_prescaler.sv - divides clk down to the phase-timing tick
module wm_tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/wm_program_controller.sv
// rtl/wm_program_controller.sv - FILL/(WASH/RINSE)xN/SPIN sequencer with pause and abort
module wm_program_controller
    import wm_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DUR_W      = 16,
    parameter int MAX_WASHES = 4,
    parameter int WCNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wm_program_controller_if.slave bus
);
    phase_t            state, next_state, saved_q, saved_d;
    logic [DUR_W-1:0]  fill_q, wash_q, rinse_q, spin_q, cur_dur;
    logic [DUR_W-1:0]  tcnt_q, tcnt_d;
    logic [WCNT_W-1:0] count_q, idx_q, idx_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              running, start, tick, phase_end, clr, en;

    assign running = state inside {PH_FILL, PH_WASH, PH_RINSE, PH_SPIN};
    assign start   = (state == PH_IDLE) && bus.coin_in && !bus.abort;

    always_comb begin
        case (state)
            PH_WASH:  cur_dur = wash_q;
            PH_RINSE: cur_dur = rinse_q;
            PH_SPIN:  cur_dur = spin_q;
            default:  cur_dur = fill_q;
        endcase
    end

    // Latched durations are never zero, so cur_dur - 1 cannot wrap.
    assign phase_end = running && tick && (tcnt_q == cur_dur - 1'b1);

    wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PH_IDLE;
            saved_q <= PH_IDLE;
            tcnt_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fill_q  <= '0;
            wash_q  <= '0;
            rinse_q <= '0;
            spin_q  <= '0;
            count_q <= '0;
        end else begin
            state   <= next_state;
            saved_q <= saved_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (start) begin
                fill_q  <= (bus.fill_dur  == '0) ? DUR_W'(1) : bus.fill_dur;
                wash_q  <= (bus.wash_dur  == '0) ? DUR_W'(1) : bus.wash_dur;
                rinse_q <= (bus.rinse_dur == '0) ? DUR_W'(1) : bus.rinse_dur;
                spin_q  <= (bus.spin_dur  == '0) ? DUR_W'(1) : bus.spin_dur;
                count_q <= WCNT_W'(clamp_count(32'(bus.wash_count), 32'(MAX_WASHES)));
            end
        end
    end

    // Abort outranks phase end, which outranks pause.
    always_comb begin
        next_state = state;
        case (state)
            PH_IDLE: begin
                if (start) next_state = PH_FILL;
            end
            PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
                if (bus.abort) begin
                    next_state = PH_IDLE;
                end else if (phase_end) begin
                    case (state)
                        PH_FILL:  next_state = PH_WASH;
                        PH_WASH:  next_state = PH_RINSE;
                        PH_RINSE: next_state = (idx_q < count_q) ? PH_WASH : PH_SPIN;
                        default:  next_state = PH_IDLE;
                    endcase
                end else if (bus.timer_pause) begin
                    next_state = PH_PAUSED;
                end
            end
            PH_PAUSED: begin
                if (bus.abort) next_state = PH_IDLE;
                else if (!bus.timer_pause) next_state = saved_q;
            end
            default: next_state = PH_IDLE;
        endcase
    end

    // Counters restart on every phase entry but survive the PAUSED round trip.
    always_comb begin
        clr     = (next_state != state) && (next_state != PH_PAUSED) &&
                  ((state != PH_PAUSED) || (next_state == PH_IDLE));
        en      = running && !bus.timer_pause;
        tcnt_d  = clr ? '0 : ((en && tick) ? tcnt_q + 1'b1 : tcnt_q);
        saved_d = (running && (next_state == PH_PAUSED)) ? state : saved_q;
        busy_d  = (next_state != PH_IDLE);
        done_d  = (state == PH_SPIN) && phase_end && !bus.abort;
        if (next_state == PH_IDLE) begin
            idx_d = '0;
        end else if (start) begin
            idx_d = WCNT_W'(1);
        end else if ((state == PH_RINSE) && (next_state == PH_WASH)) begin
            idx_d = idx_q + 1'b1;
        end else begin
            idx_d = idx_q;
        end
    end

    assign bus.phase     = state;
    assign bus.busy      = busy_q;
    assign bus.wash_idx  = idx_q;
    assign bus.wash_done = done_q;

endmodule

// File: tb/tb_wm_program_controller.sv
// tb/tb_wm_program_controller.sv - directed and random checks of wm_program_controller against a time-budget model
module tb_wm_program_controller;
    import wm_pkg::*;

    localparam int TD   = 4;
    localparam int MAXW = 4;
    localparam int NONE = 9999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wm_program_controller_if #(.DUR_W(16), .WCNT_W(3)) bus ();

    wm_program_controller #(.TICK_DIV(TD), .DUR_W(16), .MAX_WASHES(MAXW), .WCNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int passed = 0;
    int fails = 0;

    phase_t m_state = PH_IDLE;
    phase_t m_saved = PH_IDLE;
    int     m_rem = 0;
    int     m_idx = 0;
    int     m_cnt = 1;
    bit     m_done = 0;
    int     m_dur[0:7];

    int         done_cyc;
    int         pulses;
    logic [2:0] ph_log[0:127];
    logic       rp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each running phase owns dur*TD active cycles; a paused cycle spends none,
    // except the very last cycle, whose phase end beats the pause.
    task automatic model_edge();
        phase_t nxt;
        m_done = 0;
        case (m_state)
            PH_IDLE: begin
                if (bus.coin_in && !bus.abort) begin
                    m_dur[1] = (bus.fill_dur  == 0) ? 1 : int'(bus.fill_dur);
                    m_dur[2] = (bus.wash_dur  == 0) ? 1 : int'(bus.wash_dur);
                    m_dur[3] = (bus.rinse_dur == 0) ? 1 : int'(bus.rinse_dur);
                    m_dur[4] = (bus.spin_dur  == 0) ? 1 : int'(bus.spin_dur);
                    m_cnt = (bus.wash_count == 0) ? 1 : ((int'(bus.wash_count) > MAXW) ? MAXW : int'(bus.wash_count));
                    m_state = PH_FILL;
                    m_rem = m_dur[1] * TD;
                    m_idx = 1;
                end
            end
            PH_PAUSED: begin
                if (bus.abort) begin
                    m_state = PH_IDLE;
                    m_idx = 0;
                end else if (!bus.timer_pause) begin
                    m_state = m_saved;
                end
            end
            PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
                if (bus.abort) begin
                    m_state = PH_IDLE;
                    m_idx = 0;
                end else if (m_rem == 1) begin
                    if (m_state == PH_FILL) nxt = PH_WASH;
                    else if (m_state == PH_WASH) nxt = PH_RINSE;
                    else if (m_state == PH_RINSE) begin
                        if (m_idx < m_cnt) begin
                            nxt = PH_WASH;
                            m_idx++;
                        end else nxt = PH_SPIN;
                    end else nxt = PH_IDLE;
                    if (nxt == PH_IDLE) begin
                        m_idx = 0;
                        m_done = 1;
                    end else begin
                        m_rem = m_dur[nxt] * TD;
                    end
                    m_state = nxt;
                end else if (bus.timer_pause) begin
                    m_saved = m_state;
                    m_state = PH_PAUSED;
                end else begin
                    m_rem--;
                end
            end
            default: begin
                m_state = PH_IDLE;
                m_idx = 0;
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("phase", 32'(bus.phase), 32'(m_state));
        chk("busy", 32'(bus.busy), 32'(m_state != PH_IDLE));
        chk("wash_idx", 32'(bus.wash_idx), 32'(m_idx));
        chk("wash_done", 32'(bus.wash_done), 32'(m_done));
    endtask

    task automatic go_idle();
        bus.coin_in = 0;
        bus.timer_pause = 0;
        bus.abort = 1;
        cycle();
        bus.abort = 0;
        cycle();
    endtask

    // Cycle c samples the state entered on edge c-1; inputs set before call c are seen on edge c-1.
    task automatic scenario(input int cnt, input int f, input int w, input int r, input int s,
                            input int pf, input int pt, input int ab, input int cf, input int ct,
                            input int wchg, input int ncyc);
        go_idle();
        bus.wash_count = 3'(cnt);
        bus.fill_dur = 16'(f);
        bus.wash_dur = 16'(w);
        bus.rinse_dur = 16'(r);
        bus.spin_dur = 16'(s);
        done_cyc = -1;
        pulses = 0;
        for (int c = 1; c <= ncyc; c++) begin
            bus.coin_in = (c == 1) || ((c - 1 >= cf) && (c - 1 <= ct));
            bus.timer_pause = (c - 1 >= pf) && (c - 1 <= pt);
            bus.abort = (c - 1 == ab);
            if (c - 1 >= wchg) bus.wash_count = 3'd1;
            cycle();
            ph_log[c] = bus.phase;
            if (bus.wash_done === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        bus.coin_in = 0;
        bus.timer_pause = 0;
        bus.abort = 0;
    endtask

    initial begin
        bus.coin_in = 0;
        bus.abort = 0;
        bus.timer_pause = 0;
        bus.wash_count = 0;
        bus.fill_dur = 0;
        bus.wash_dur = 0;
        bus.rinse_dur = 0;
        bus.spin_dur = 0;
        for (int i = 0; i < 8; i++) m_dur[i] = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_phase", 32'(bus.phase), 32'(PH_IDLE));
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_idx", 32'(bus.wash_idx), 0);
        chk("reset_done", 32'(bus.wash_done), 0);
        rst_n = 1;

        scenario(1, 2, 3, 2, 2, NONE, NONE, NONE, NONE, NONE, NONE, 42);
        chk("nom_done_cycle", done_cyc, 37);
        chk("nom_pulses", pulses, 1);
        chk("nom_fill_end", 32'(ph_log[8]), 32'(PH_FILL));
        chk("nom_wash_start", 32'(ph_log[9]), 32'(PH_WASH));
        chk("nom_spin_end", 32'(ph_log[36]), 32'(PH_SPIN));

        scenario(3, 2, 3, 2, 2, NONE, NONE, NONE, NONE, NONE, NONE, 80);
        chk("multi_done_cycle", done_cyc, 77);

        scenario(0, 2, 3, 2, 2, NONE, NONE, NONE, NONE, NONE, NONE, 40);
        chk("count0_done_cycle", done_cyc, 37);

        scenario(7, 2, 3, 2, 2, NONE, NONE, NONE, 5, 30, 20, 100);
        chk("count7_done_cycle", done_cyc, 97);
        chk("count7_pulses", pulses, 1);

        scenario(1, 0, 3, 2, 2, NONE, NONE, NONE, NONE, NONE, NONE, 36);
        chk("fill0_last", 32'(ph_log[4]), 32'(PH_FILL));
        chk("fill0_wash", 32'(ph_log[5]), 32'(PH_WASH));
        chk("fill0_done_cycle", done_cyc, 33);

        scenario(1, 2, 3, 2, 2, 12, 21, NONE, NONE, NONE, NONE, 52);
        chk("pause_phase", 32'(ph_log[15]), 32'(PH_PAUSED));
        chk("pause_done_cycle", done_cyc, 48);

        scenario(1, 2, 3, 2, 2, NONE, NONE, 15, NONE, NONE, NONE, 45);
        chk("abort_idle", 32'(ph_log[16]), 32'(PH_IDLE));
        chk("abort_no_done", pulses, 0);

        scenario(1, 2, 3, 2, 2, 10, 14, 12, NONE, NONE, NONE, 30);
        chk("abort_pause_paused", 32'(ph_log[11]), 32'(PH_PAUSED));
        chk("abort_pause_idle", 32'(ph_log[13]), 32'(PH_IDLE));
        chk("abort_pause_no_done", pulses, 0);

        scenario(1, 2, 3, 2, 2, 8, 12, NONE, NONE, NONE, NONE, 14);
        chk("pause_edge_wash", 32'(ph_log[9]), 32'(PH_WASH));
        chk("pause_edge_paused", 32'(ph_log[10]), 32'(PH_PAUSED));

        scenario(1, 2, 3, 2, 2, NONE, NONE, NONE, 37, 37, NONE, 40);
        chk("restart_done", done_cyc, 37);
        chk("restart_fill", 32'(ph_log[38]), 32'(PH_FILL));

        scenario(1, 2, 3, 2, 2, NONE, NONE, NONE, NONE, NONE, NONE, 5);
        force dut.state = 3'd7;
        #1;
        release dut.state;
        m_state = 3'd7;
        cycle();
        chk("illegal_recover", 32'(bus.phase), 32'(PH_IDLE));

        scenario(1, 2, 3, 2, 2, NONE, NONE, NONE, NONE, NONE, NONE, 31);
        chk("pre_reset_spin", 32'(bus.phase), 32'(PH_SPIN));
        rst_n = 0;
        #1;
        chk("rst_phase", 32'(bus.phase), 32'(PH_IDLE));
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_idx", 32'(bus.wash_idx), 0);
        chk("rst_done", 32'(bus.wash_done), 0);
        m_state = PH_IDLE;
        m_idx = 0;
        m_done = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            bus.coin_in = ($urandom_range(0, 7) == 0);
            bus.abort = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 14) == 0) rp = ~rp;
            bus.timer_pause = rp;
            bus.wash_count = 3'($urandom_range(0, 7));
            bus.fill_dur = 16'($urandom_range(0, 3));
            bus.wash_dur = 16'($urandom_range(0, 3));
            bus.rinse_dur = 16'($urandom_range(0, 3));
            bus.spin_dur = 16'($urandom_range(0, 3));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
